tsi_serial_responder: RTL and testbench

//   Target-side endpoint of the 32-bit serial TSI link driven by the host-side simulation bridge.

---
 rtl/tsi_pkg.sv | 34 +++
 rtl/tsi_serial_responder.sv | 172 +++++++++++++++++
 tb/tb_tsi_serial_responder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsi_pkg.sv
// Shared definitions for the serial TSI responder: command codes, link word
// width and the responder's packet-parsing state set.
package tsi_pkg;

    localparam int TSI_W = 32;

    localparam logic [TSI_W-1:0] TSI_CMD_READ  = 32'd0;
    localparam logic [TSI_W-1:0] TSI_CMD_WRITE = 32'd1;

    typedef enum logic [3:0] {
        ST_CMD,
        ST_ADDR_LO,
        ST_ADDR_HI,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_WDATA,
        ST_WREQ,
        ST_WACK,
        ST_RREQ,
        ST_RRESP,
        ST_RSEND
    } tsi_resp_state_e;

    // States in which a host word is consumed from serial_in.
    function automatic logic accepts_serial_in(input tsi_resp_state_e s);
        return s inside {ST_CMD, ST_ADDR_LO, ST_ADDR_HI, ST_LEN_LO, ST_LEN_HI, ST_WDATA};
    endfunction

    // States in which a memory response is expected.
    function automatic logic expects_mem_resp(input tsi_resp_state_e s);
        return s inside {ST_WACK, ST_RRESP};
    endfunction

endpackage

// File: rtl/tsi_serial_responder.sv
// Target-side TSI endpoint: parses host packets (cmd, addr lo/hi, len lo/hi,
// write data) from serial_in and executes them one word at a time on a
// req/resp memory port; read data goes back to the host on serial_out.
// Only one memory request is ever outstanding.
module tsi_serial_responder
    import tsi_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 32
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 serial_in_valid,
    output logic                 serial_in_ready,
    input  logic [TSI_W-1:0]     serial_in_bits,

    output logic                 serial_out_valid,
    input  logic                 serial_out_ready,
    output logic [TSI_W-1:0]     serial_out_bits,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_write,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [TSI_W-1:0]     mem_req_wdata,

    input  logic                 mem_resp_valid,
    input  logic [TSI_W-1:0]     mem_resp_data,

    output logic                 error
);

    tsi_resp_state_e      state_q, state_d;
    logic                 cmd_write_q, cmd_write_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic [TSI_W-1:0]     data_q, data_d;
    logic                 error_q, error_d;

    logic                 in_fire;
    logic [31:0]          addr_lo32;

    // Ready is withheld while reset is held so no word is taken during reset.
    assign serial_in_ready  = reset && accepts_serial_in(state_q);
    assign serial_out_valid = (state_q == ST_RSEND);
    assign serial_out_bits  = data_q;
    assign mem_req_valid    = (state_q == ST_WREQ) || (state_q == ST_RREQ);
    assign mem_req_write    = (state_q == ST_WREQ);
    assign mem_req_addr     = addr_q;
    assign mem_req_wdata    = data_q;
    assign error            = error_q;

    assign in_fire   = serial_in_valid && serial_in_ready;
    assign addr_lo32 = 32'(addr_q);

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CMD;
            cmd_write_q <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            data_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            data_q      <= data_d;
            error_q     <= error_d;
        end
    end

    // Packet parser and per-word transaction sequencing.
    always_comb begin
        // NOTE: hold-current defaults first, so no path can infer a latch.
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        addr_d      = addr_q;
        len_d       = len_q;
        data_d      = data_q;
        error_d     = error_q;

        if (mem_resp_valid && !expects_mem_resp(state_q)) begin
            error_d = 1'b1;
        end

        unique case (state_q)
            ST_CMD: begin
                if (in_fire) begin
                    if (serial_in_bits == TSI_CMD_READ) begin
                        cmd_write_d = 1'b0;
                        state_d     = ST_ADDR_LO;
                    end else if (serial_in_bits == TSI_CMD_WRITE) begin
                        cmd_write_d = 1'b1;
                        state_d     = ST_ADDR_LO;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_ADDR_LO: begin
                if (in_fire) begin
                    addr_d  = ADDR_BITS'(serial_in_bits);
                    state_d = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: begin
                if (in_fire) begin
                    addr_d  = ADDR_BITS'({serial_in_bits, addr_lo32});
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (in_fire) begin
                    len_d   = LEN_BITS'(serial_in_bits);
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (in_fire) begin
                    state_d = cmd_write_q ? ST_WDATA : ST_RREQ;
                end
            end
            ST_WDATA: begin
                if (in_fire) begin
                    data_d  = serial_in_bits;
                    state_d = ST_WREQ;
                end
            end
            ST_WREQ: begin
                if (mem_req_ready) state_d = ST_WACK;
            end
            ST_WACK: begin
                if (mem_resp_valid) begin
                    if (len_q == '0) begin
                        state_d = ST_CMD;
                    end else begin
                        len_d   = len_q - LEN_BITS'(1);
                        addr_d  = addr_q + ADDR_BITS'(4);
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RREQ: begin
                if (mem_req_ready) state_d = ST_RRESP;
            end
            ST_RRESP: begin
                if (mem_resp_valid) begin
                    data_d  = mem_resp_data;
                    state_d = ST_RSEND;
                end
            end
            ST_RSEND: begin
                if (serial_out_ready) begin
                    if (len_q == '0) begin
                        state_d = ST_CMD;
                    end else begin
                        len_d   = len_q - LEN_BITS'(1);
                        addr_d  = addr_q + ADDR_BITS'(4);
                        state_d = ST_RREQ;
                    end
                end
            end
            default: state_d = ST_CMD;
        endcase
    end

endmodule

// File: tb/tb_tsi_serial_responder.sv
// Self-checking bench for tsi_serial_responder. A packet-level model expands
// each host packet into the memory operations and serial_out words it must
// produce; one monitor/responder process plays the memory and host receiver
// and compares every handshake against that model.
module tb_tsi_serial_responder;
    import tsi_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        serial_in_valid = 1'b0;
    logic        serial_in_ready;
    logic [31:0] serial_in_bits = '0;
    logic        serial_out_valid;
    logic        serial_out_ready = 1'b0;
    logic [31:0] serial_out_bits;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_write;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        error;

    tsi_serial_responder #(.ADDR_BITS(32), .LEN_BITS(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .serial_in_valid  (serial_in_valid),
        .serial_in_ready  (serial_in_ready),
        .serial_in_bits   (serial_in_bits),
        .serial_out_valid (serial_out_valid),
        .serial_out_ready (serial_out_ready),
        .serial_out_bits  (serial_out_bits),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_req_write    (mem_req_write),
        .mem_req_addr     (mem_req_addr),
        .mem_req_wdata    (mem_req_wdata),
        .mem_resp_valid   (mem_resp_valid),
        .mem_resp_data    (mem_resp_data),
        .error            (error)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    op_t         exp_ops[$];
    logic [31:0] exp_out[$];
    logic [31:0] pkt_words[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bus_mem[logic [31:0]];

    int checks = 0;
    int errors = 0;

    bit stall_mode  = 0;
    bit gap_mode    = 0;
    bit hold_out    = 0;
    bit inject_resp = 0;

    bit          resp_pend = 0;
    int          resp_wait = 0;
    logic [31:0] resp_word = '0;
    int          req_stall = 0;
    int          out_stall = 0;

    int          req_cnt = 0;
    int          out_cnt = 0;
    logic        last_req_write = 1'b0;
    logic [31:0] last_req_addr  = '0;
    logic [31:0] last_req_wdata = '0;
    logic [31:0] last_out       = '0;

    bit          req_stalled = 0;
    bit          out_stalled = 0;
    logic        prev_write  = 1'b0;
    logic [31:0] prev_addr   = '0;
    logic [31:0] prev_wdata  = '0;
    logic [31:0] prev_out    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", name);
    endtask

    // Contents of any word never written since the start of the run.
    function automatic logic [31:0] mem_default(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_default(a);
    endfunction

    // Model of a write packet: len+1 writes at addr, addr+4, ... (mod 2^32).
    task automatic plan_write(input logic [31:0] addr, input logic [31:0] addr_hi,
                              input logic [31:0] len, input logic [31:0] len_hi,
                              input logic [31:0] d0);
        logic [31:0] a;
        logic [31:0] d;
        pkt_words = {TSI_CMD_WRITE, addr, addr_hi, len, len_hi};
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 32'(4 * i);
            d = (i == 0) ? d0 : $urandom;
            pkt_words.push_back(d);
            ref_mem[a] = d;
            exp_ops.push_back('{wr: 1'b1, addr: a, data: d});
        end
    endtask

    // Model of a read packet: len+1 reads, each returned on serial_out in order.
    task automatic plan_read(input logic [31:0] addr, input logic [31:0] addr_hi,
                             input logic [31:0] len, input logic [31:0] len_hi);
        logic [31:0] a;
        pkt_words = {TSI_CMD_READ, addr, addr_hi, len, len_hi};
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 32'(4 * i);
            exp_ops.push_back('{wr: 1'b0, addr: a, data: 32'h0});
            exp_out.push_back(ref_read(a));
        end
    endtask

    // Offer one word on serial_in; entered and left just after a rising edge.
    task automatic send_word(input logic [31:0] w);
        int n;
        serial_in_bits  = w;
        serial_in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clock);
            if (serial_in_ready) begin
                @(posedge clock); #1;
                break;
            end
            @(posedge clock); #1;
            n++;
            if (n > 500) begin
                fail_bound("serial_in_accept");
                break;
            end
        end
        serial_in_valid = 1'b0;
        serial_in_bits  = $urandom;
        if (gap_mode) repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    endtask

    task automatic send_packet();
        foreach (pkt_words[i]) send_word(pkt_words[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_ops.size() != 0 || exp_out.size() != 0 || resp_pend) && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        if (n >= 3000) fail_bound("packet_complete");
        repeat (2) begin @(posedge clock); #1; end
    endtask

    // Memory / host-receiver model and the single per-cycle compare process.
    always begin
        @(posedge clock); #1;
        mem_resp_valid = 1'b0;
        if (inject_resp) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
            inject_resp    = 0;
        end else if (resp_pend) begin
            if (resp_wait == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = resp_word;
                resp_pend      = 0;
            end else begin
                resp_wait--;
            end
        end
        mem_req_ready = (req_stall == 0);
        if (req_stall > 0) req_stall--;
        serial_out_ready = !hold_out && (out_stall == 0);
        if (out_stall > 0) out_stall--;

        @(negedge clock);
        if (!reset) begin
            req_stalled = 0;
            out_stalled = 0;
            resp_pend   = 0;
        end else begin
            if (req_stalled) begin
                check("req_hold_valid", mem_req_valid, 1);
                check("req_hold_write", mem_req_write, prev_write);
                check("req_hold_addr", mem_req_addr, prev_addr);
                check("req_hold_wdata", mem_req_wdata, prev_wdata);
            end
            if (out_stalled) begin
                check("out_hold_valid", serial_out_valid, 1);
                check("out_hold_bits", serial_out_bits, prev_out);
            end

            if (mem_req_valid && mem_req_ready) begin
                if (exp_ops.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req actual=addr_0x%08h required=none", mem_req_addr);
                end else begin
                    op_t e;
                    e = exp_ops.pop_front();
                    check("req_write", mem_req_write, e.wr);
                    check("req_addr", mem_req_addr, e.addr);
                    if (e.wr) check("req_wdata", mem_req_wdata, e.data);
                end
                if (mem_req_write) begin
                    bus_mem[mem_req_addr] = mem_req_wdata;
                    resp_word = $urandom;
                end else begin
                    resp_word = bus_mem.exists(mem_req_addr) ? bus_mem[mem_req_addr]
                                                             : mem_default(mem_req_addr);
                end
                resp_pend      = 1;
                resp_wait      = stall_mode ? $urandom_range(0, 3) : 0;
                req_cnt++;
                last_req_write = mem_req_write;
                last_req_addr  = mem_req_addr;
                last_req_wdata = mem_req_wdata;
                if (stall_mode) req_stall = $urandom_range(0, 5);
            end
            req_stalled = mem_req_valid && !mem_req_ready;
            prev_write  = mem_req_write;
            prev_addr   = mem_req_addr;
            prev_wdata  = mem_req_wdata;

            if (serial_out_valid && serial_out_ready) begin
                if (exp_out.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_serial_out actual=0x%08h required=none", serial_out_bits);
                end else begin
                    check("serial_out_bits", serial_out_bits, exp_out.pop_front());
                end
                out_cnt++;
                last_out = serial_out_bits;
                if (stall_mode) out_stall = $urandom_range(0, 5);
            end
            out_stalled = serial_out_valid && !serial_out_ready;
            prev_out    = serial_out_bits;
        end
    end

    initial begin
        int base_req;
        int base_out;
        logic [31:0] a;
        int n;

        // Reset state.
        #1;
        check("rst_serial_in_ready", serial_in_ready, 0);
        check("rst_serial_out_valid", serial_out_valid, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_error", error, 0);
        repeat (3) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        check("post_rst_serial_in_ready", serial_in_ready, 1);
        @(posedge clock); #1;

        // Single-word write; no serial response expected.
        base_req = req_cnt;
        base_out = out_cnt;
        plan_write(32'h0000_1000, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF);
        send_packet();
        wait_idle();
        check("w1_req_count", 32'(req_cnt - base_req), 1);
        check("w1_addr", last_req_addr, 32'h0000_1000);
        check("w1_wdata", last_req_wdata, 32'hDEAD_BEEF);
        check("w1_write", last_req_write, 1);
        check("w1_no_serial_out", 32'(out_cnt - base_out), 0);

        // Read it back.
        plan_read(32'h0000_1000, 32'h0, 32'h0, 32'h0);
        send_packet();
        wait_idle();
        check("r1_data", last_out, 32'hDEAD_BEEF);

        // Four-word read of untouched memory.
        base_out = out_cnt;
        plan_read(32'h0000_2000, 32'h0, 32'h3, 32'h0);
        send_packet();
        wait_idle();
        check("r4_count", 32'(out_cnt - base_out), 4);
        check("r4_last_addr", last_req_addr, 32'h0000_200C);
        check("r4_last_data", last_out, 32'h5A5A_85A9);

        // Write crossing the top of the address space.
        base_req = req_cnt;
        plan_write(32'hFFFF_FFFC, 32'h0, 32'h1, 32'h0, 32'h1234_5678);
        send_packet();
        wait_idle();
        check("wrap_req_count", 32'(req_cnt - base_req), 2);
        check("wrap_last_addr", last_req_addr, 32'h0000_0000);
        check("no_error_yet", error, 0);

        // Randomized packets with gaps and backpressure on every interface.
        stall_mode = 1;
        gap_mode   = 1;
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       a = $urandom;
                default: a = 32'h0000_4000 | ($urandom & 32'h3C);
            endcase
            if ($urandom_range(0, 1) == 1)
                plan_write(a, $urandom, 32'($urandom_range(0, 4)), $urandom, $urandom);
            else
                plan_read(a, $urandom, 32'($urandom_range(0, 4)), $urandom);
            send_packet();
        end
        wait_idle();
        stall_mode = 0;
        gap_mode   = 0;
        check("random_no_error", error, 0);

        // Unsolicited memory response while idle.
        inject_resp = 1;
        repeat (3) begin @(posedge clock); #1; end
        check("unsolicited_error", error, 1);
        check("unsolicited_ready", serial_in_ready, 1);

        // Reset while a read word is stalled on serial_out.
        hold_out = 1;
        plan_read(32'h0000_3000, 32'h0, 32'h2, 32'h0);
        send_packet();
        n = 0;
        forever begin
            @(negedge clock);
            if (serial_out_valid) break;
            n++;
            if (n > 500) begin
                fail_bound("reach_rsend");
                break;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        check("rsend_rst_out_valid", serial_out_valid, 0);
        check("rsend_rst_req_valid", mem_req_valid, 0);
        exp_ops.delete();
        exp_out.delete();
        hold_out = 0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b1;
        #1;
        check("rsend_rst_error_clear", error, 0);
        check("rsend_rst_ready", serial_in_ready, 1);
        @(posedge clock); #1;

        // Illegal command, then a normal (wrapping) read.
        pkt_words = {32'h0000_0007};
        send_packet();
        repeat (2) begin @(posedge clock); #1; end
        check("illegal_error", error, 1);
        check("illegal_stay_cmd", serial_in_ready, 1);
        base_out = out_cnt;
        plan_read(32'hFFFF_FFFC, 32'h0, 32'h1, 32'h0);
        send_packet();
        wait_idle();
        check("after_illegal_count", 32'(out_cnt - base_out), 2);
        check("after_illegal_last_addr", last_req_addr, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run ends even if a bounded wait misbehaves.
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

endmodule
